turfio_cin_tx: RTL and testbench



---
 rtl/turfio_cin_tx.sv | 157 +++++++++++++++
 tb/tb_turfio_cin_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turfio_cin_tx.sv
// Transmit end of the TURFIO->TURF CIN link: buffers 16-bit trigger words in a
// FWFT FIFO and emits one framed 32-bit word per clock, or the training pattern.
module turfio_cin_tx #(
    parameter logic [31:0] TRAIN_VALUE = 32'hA55A6996,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        phase_i,
    input  logic                        train_i,
    input  logic                        err_clr_i,
    input  logic [15:0]                 trig_dat_i,
    input  logic                        trig_valid_i,
    output logic                        trig_ready_o,
    output logic [31:0]                 dout_o,
    output logic                        training_o,
    output logic                        phase_err_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_TRAIN = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        state_reg, state_next;

    logic [2:0]    slot_reg;
    logic [2:0]    cur_slot;
    logic          phase_err_reg;
    logic          phase_err_set;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          full, empty, push, pop;
    logic [15:0]   head;

    logic          emit;
    logic [11:0]   seq_reg, seq_next;
    logic [31:0]   dout_reg, dout_next;
    logic          training_reg;

    // cur_slot is the slot of the word being built this cycle; a phase pulse
    // always realigns it to 0, and is only legitimate right after slot 7.
    assign cur_slot      = phase_i ? 3'd0 : slot_reg + 3'd1;
    assign phase_err_set = phase_i && (slot_reg != 3'd7);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_reg      <= 3'd0;
            phase_err_reg <= 1'b0;
        end else begin
            slot_reg <= cur_slot;
            if (phase_err_set)
                phase_err_reg <= 1'b1;
            else if (err_clr_i)
                phase_err_reg <= 1'b0;
        end
    end

    // Trigger FIFO: first-word-fall-through, head read straight from the array.
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign push  = trig_valid_i && !full;
    assign head  = mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr_reg] <= trig_dat_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_reg <= ST_TRAIN;
        else
            state_reg <= state_next;
    end

    // Leaving RUN waits for the slot-7 word so a frame is never cut short.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_TRAIN: begin
                if (!train_i)
                    state_next = ST_ARM;
            end
            ST_ARM: begin
                if (train_i)
                    state_next = ST_TRAIN;
                else if (phase_i)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (train_i && (cur_slot == 3'd7))
                    state_next = ST_TRAIN;
            end
            default: state_next = ST_TRAIN;
        endcase
    end

    // The ARM cycle that sees phase_i already builds the slot-0 word, so the
    // first frame lines up with the phase sequence.
    always_comb begin
        emit      = 1'b0;
        dout_next = TRAIN_VALUE;
        case (state_reg)
            ST_RUN:  emit = 1'b1;
            ST_ARM:  emit = phase_i && !train_i;
            default: emit = 1'b0;
        endcase
        pop      = emit && !empty;
        seq_next = seq_reg + {11'd0, pop};
        if (emit)
            dout_next = {(pop ? head : 16'h0000), pop, cur_slot, seq_reg};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seq_reg      <= 12'd0;
            dout_reg     <= 32'h0;
            training_reg <= 1'b1;
        end else begin
            seq_reg      <= seq_next;
            dout_reg     <= dout_next;
            training_reg <= !emit;
        end
    end

    assign trig_ready_o = !full;
    assign dout_o       = dout_reg;
    assign training_o   = training_reg;
    assign phase_err_o  = phase_err_reg;
    assign fifo_count_o = count_reg;

endmodule

// File: tb/tb_turfio_cin_tx.sv
// Bench for turfio_cin_tx: directed stimulus with a trigger scoreboard checked
// by an independent monitor on every RUN word.
module tb_turfio_cin_tx;
    localparam logic [31:0] TRAIN_VALUE = 32'hA55A6996;

    logic        clk_i        = 1'b0;
    logic        rst_n_i      = 1'b0;
    logic        phase_i      = 1'b0;
    logic        train_i      = 1'b1;
    logic        err_clr_i    = 1'b0;
    logic [15:0] trig_dat_i   = 16'h0;
    logic        trig_valid_i = 1'b0;
    logic        trig_ready_o;
    logic [31:0] dout_o;
    logic        training_o;
    logic        phase_err_o;
    logic [4:0]  fifo_count_o;

    turfio_cin_tx #(
        .TRAIN_VALUE(TRAIN_VALUE),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .phase_i     (phase_i),
        .train_i     (train_i),
        .err_clr_i   (err_clr_i),
        .trig_dat_i  (trig_dat_i),
        .trig_valid_i(trig_valid_i),
        .trig_ready_o(trig_ready_o),
        .dout_o      (dout_o),
        .training_o  (training_o),
        .phase_err_o (phase_err_o),
        .fifo_count_o(fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    int          ncmp = 0;
    int          nerr = 0;
    logic [27:0] exp_q[$];
    logic [11:0] tx_seq = 12'd0;
    logic [11:0] mon_seq = 12'd0;
    logic [11:0] prev_seq = 12'd0;
    bit          saw_wrap = 1'b0;
    int          cyc_n = 0;
    int          last_ph_cyc = -100;
    logic [2:0]  ph_cnt = 3'd0;
    bit          ph_mask = 1'b0;
    bit          ph_inject = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input int budget, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        trig_dat_i   = d;
        trig_valid_i = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_i);
            if (trig_ready_o) begin
                ok  = 1'b1;
                acc = cyc_n;
                exp_q.push_back({d, tx_seq});
                tx_seq = tx_seq + 12'd1;
            end
            tick();
        end
        trig_valid_i = 1'b0;
        check("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_slot(input logic [2:0] s);
        for (int i = 0; i < 16 && ph_cnt != s; i++)
            tick();
    endtask

    task automatic wait_training(input int budget);
        int i;
        i = 0;
        @(negedge clk_i);
        while (!training_o && i < budget) begin
            @(negedge clk_i);
            i++;
        end
        check("enter_train", 32'(training_o), 32'd1);
        tick();
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++)
            tick();
        @(negedge clk_i);
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    // Phase generator: ph_cnt is the slot the word on dout carries this cycle.
    always @(posedge clk_i) begin
        if (phase_i && rst_n_i)
            last_ph_cyc = cyc_n;
        cyc_n++;
        if (!rst_n_i || phase_i)
            ph_cnt = 3'd0;
        else
            ph_cnt = ph_cnt + 3'd1;
        #2;
        phase_i = ((ph_cnt == 3'd7) && !ph_mask) || ph_inject;
    end

    always @(negedge clk_i) begin : monitor
        logic [27:0] e;
        if (!rst_n_i) begin
            mon_seq  = 12'd0;
            prev_seq = 12'd0;
        end else if (!training_o) begin
            check("run_slot", 32'(dout_o[14:12]), 32'(ph_cnt));
            if (dout_o[15]) begin
                if (exp_q.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL sb_unexpected: got %08h expected no trigger", dout_o);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_payload", 32'(dout_o[31:16]), 32'(e[27:12]));
                    check("sb_seq", 32'(dout_o[11:0]), 32'(e[11:0]));
                    if (dout_o[11:0] == 12'h000 && prev_seq == 12'hFFF)
                        saw_wrap = 1'b1;
                    prev_seq = dout_o[11:0];
                    mon_seq  = e[11:0] + 12'd1;
                end
            end else begin
                check("idle_payload", 32'(dout_o[31:16]), 32'h0);
                check("idle_seq", 32'(dout_o[11:0]), 32'(mon_seq));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        repeat (3) tick();
        @(negedge clk_i);
        check("rst_dout", dout_o, 32'h0);
        check("rst_training", 32'(training_o), 32'd1);
        check("rst_ready", 32'(trig_ready_o), 32'd1);
        check("rst_perr", 32'(phase_err_o), 32'd0);
        check("rst_count", 32'(fifo_count_o), 32'd0);
        tick();
        tick();
        rst_n_i = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk_i);
            check("train_dout", dout_o, TRAIN_VALUE);
            check("train_training", 32'(training_o), 32'd1);
            check("train_ready", 32'(trig_ready_o), 32'd1);
            check("train_perr", 32'(phase_err_o), 32'd0);
        end

        // First RUN word and trigger latency.
        tick();
        train_i = 1'b0;
        tick();
        wait_slot(3'd6);
        send(16'hBEEF, 4, acc);
        tick();
        @(negedge clk_i);
        check("first_word", dout_o, 32'hBEEF_8000);
        check("first_training", 32'(training_o), 32'd0);
        tick();
        @(negedge clk_i);
        check("second_word", dout_o, 32'h0000_1001);

        // Backpressure: fill in ARM with phase held off.
        tick();
        train_i = 1'b1;
        wait_training(40);
        ph_mask = 1'b1;
        train_i = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 16; i++)
            send(16'(i), 4, acc);
        @(negedge clk_i);
        check("bp_ready", 32'(trig_ready_o), 32'd0);
        check("bp_count", 32'(fifo_count_o), 32'd16);
        tick();
        ph_mask = 1'b0;
        send(16'h0010, 24, acc);
        check("bp_accept_cycle", acc, last_ph_cyc + 1);
        wait_drain(60);

        // Long stream through the seq wrap.
        tick();
        for (int i = 0; i < 4097; i++)
            send(16'(32'h1000 + i), 4, acc);
        wait_drain(60);
        check("seq_wrap_seen", 32'(saw_wrap), 32'd1);

        // Phase error, clear, and set-wins-over-clear.
        tick();
        wait_slot(3'd3);
        ph_inject = 1'b1;
        tick();
        ph_inject = 1'b0;
        @(negedge clk_i);
        check("perr_set", 32'(phase_err_o), 32'd1);
        check("perr_realign_slot", 32'(dout_o[14:12]), 32'd0);
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        @(negedge clk_i);
        check("perr_clear", 32'(phase_err_o), 32'd0);
        tick();
        wait_slot(3'd5);
        ph_inject = 1'b1;
        err_clr_i = 1'b1;
        tick();
        ph_inject = 1'b0;
        err_clr_i = 1'b0;
        @(negedge clk_i);
        check("perr_set_wins", 32'(phase_err_o), 32'd1);
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        @(negedge clk_i);
        check("perr_clear2", 32'(phase_err_o), 32'd0);

        // Training requested mid-frame while triggers keep arriving.
        tick();
        wait_slot(3'd2);
        train_i = 1'b1;
        fork
            begin
                int a2;
                for (int i = 0; i < 12; i++)
                    send(16'(32'hC000 + i), 8, a2);
            end
            begin
                for (int k = 3; k <= 7; k++) begin
                    tick();
                    @(negedge clk_i);
                    check("tmf_slot", 32'(dout_o[14:12]), 32'(k));
                    check("tmf_running", 32'(training_o), 32'd0);
                end
                tick();
                @(negedge clk_i);
                check("tmf_train_dout", dout_o, TRAIN_VALUE);
                check("tmf_training", 32'(training_o), 32'd1);
            end
        join
        @(negedge clk_i);
        check("tmf_retained", 32'(fifo_count_o), 32'd8);
        tick();
        train_i = 1'b0;
        wait_drain(60);

        // Asynchronous reset in the middle of a frame.
        tick();
        for (int i = 0; i < 3; i++)
            send(16'(32'hD000 + i), 4, acc);
        rst_n_i = 1'b0;
        #1;
        check("arst_dout", dout_o, 32'h0);
        check("arst_training", 32'(training_o), 32'd1);
        check("arst_count", 32'(fifo_count_o), 32'd0);
        check("arst_ready", 32'(trig_ready_o), 32'd1);
        exp_q.delete();
        tx_seq = 12'd0;
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
        @(negedge clk_i);
        check("post_rst_dout", dout_o, TRAIN_VALUE);
        check("post_rst_training", 32'(training_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
